alu_mdu: RTL



---
 rtl/alu_mdu.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// Multi-cycle execute ALU: single-step integer ops plus iterative shift-add
// multiply and restoring divide, behind a start/busy/done handshake.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       AluControl,
  input  logic [WIDTH-1:0] ScrA,
  input  logic [WIDTH-1:0] ScrB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;      // {is_div, high_or_rem}
  logic [WIDTH-1:0]   opa_q, opa_d;    // multiplicand, or divisor magnitude
  logic [2*WIDTH-1:0] acc_q, acc_d;    // product {hi,lo}, or {remainder,quotient}
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic               zero_q, zero_d;

  logic               accept, iter_op, sgn_op, a_neg, b_neg, div_ge;
  logic [WIDTH-1:0]   a_mag, b_mag, single_res, div_rn, quo, rem, final_res;
  logic [WIDTH:0]     mul_sum, div_rs;
  logic [2*WIDTH-1:0] mul_next, div_next;

  assign accept  = start && (state_q != RUN);
  assign iter_op = AluControl[3] && (AluControl[2] || !AluControl[1]);
  assign sgn_op  = (AluControl[3:1] == 3'b111);
  assign a_neg   = sgn_op && ScrA[WIDTH-1];
  assign b_neg   = sgn_op && ScrB[WIDTH-1];
  assign a_mag   = a_neg ? -ScrA : ScrA;
  assign b_mag   = b_neg ? -ScrB : ScrB;

  always_comb begin
    single_res = '0;
    case (AluControl)
      4'b0000: single_res = ScrA + ScrB;
      4'b0001: single_res = ScrA - ScrB;
      4'b0010: single_res = ScrA & ScrB;
      4'b0011: single_res = ScrA | ScrB;
      4'b0101: single_res = {{(WIDTH-1){1'b0}}, ($signed(ScrA) < $signed(ScrB))};
      4'b0110: single_res = {{(WIDTH-1){1'b0}}, (ScrA < ScrB)};
      default: single_res = '0;
    endcase
  end

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  assign div_rs   = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge   = (div_rs >= {1'b0, opa_q});
  assign div_rn   = div_ge ? WIDTH'(div_rs - {1'b0, opa_q}) : div_rs[WIDTH-1:0];
  assign div_next = {div_rn, acc_q[WIDTH-2:0], div_ge};

  // A zero divisor leaves the all-ones quotient untouched even for signed DIV.
  assign quo = (negq_q && (opa_q != '0)) ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
  assign rem = negr_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
  assign final_res = op_q[1] ? (op_q[0] ? rem : quo)
                             : (op_q[0] ? mul_next[2*WIDTH-1:WIDTH] : mul_next[WIDTH-1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    res_d   = res_q;
    zero_d  = zero_q;
    if (accept) begin
      op_d = {AluControl[2], AluControl[0]};
      if (iter_op) begin
        state_d = RUN;
        cnt_d   = CNTW'(WIDTH);
        if (AluControl[2]) begin
          opa_d  = b_mag;
          acc_d  = {{WIDTH{1'b0}}, a_mag};
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
        end else begin
          opa_d  = ScrA;
          acc_d  = {{WIDTH{1'b0}}, ScrB};
          negq_d = 1'b0;
          negr_d = 1'b0;
        end
      end else begin
        state_d = DONE;
        res_d   = single_res;
        zero_d  = (single_res == '0);
      end
    end else if (state_q == RUN) begin
      acc_d = op_q[1] ? div_next : mul_next;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNTW'(1)) begin
        state_d = DONE;
        res_d   = final_res;
        zero_d  = (final_res == '0);
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign ALUResult = res_q;
  assign zero      = zero_q;

endmodule
